// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: section type codes and FSM state encoding.
package loader_pkg;

    localparam logic [7:0] TYPE_I = 8'h49;
    localparam logic [7:0] TYPE_D = 8'h44;
    localparam logic [7:0] TYPE_E = 8'h45;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR_TYPE = 4'd1,
        ST_HDR_BASE = 4'd2,
        ST_HDR_CNT  = 4'd3,
        ST_WORD_HI  = 4'd4,
        ST_WORD_LO  = 4'd5,
        ST_CHK      = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } state_t;

    // States in which the loader consumes bytes from the stream.
    function automatic logic takes_bytes(state_t s);
        return s inside {ST_HDR_TYPE, ST_HDR_BASE, ST_HDR_CNT,
                         ST_WORD_HI, ST_WORD_LO, ST_CHK};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and external memory-load bus of the boot loader.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        ext_inst_we;
    logic        ext_data_we;
    logic [15:0] ext_addr;
    logic [15:0] ext_data;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, ext_inst_we, ext_data_we, ext_addr, ext_data
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, ext_inst_we, ext_data_we, ext_addr, ext_data
    );
endinterface

// File: rtl/loader_csum.sv
// 8-bit running sum (mod 256) of the bytes of one load session.
module loader_csum (
    input  logic       clk_op,
    input  logic       rst_D4,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] value
);
    logic [7:0] sum_reg;

    always_ff @(posedge clk_op or negedge rst_D4) begin
        if (!rst_D4) begin
            sum_reg <= 8'd0;
        end else if (clr) begin
            sum_reg <= 8'd0;
        end else if (add) begin
            sum_reg <= sum_reg + din;
        end
    end

    assign value = sum_reg;
endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> 16-bit word writes into the core's inst/data memories.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int         MEM_AW = 8,
    parameter logic [7:0] TYPE_I = loader_pkg::TYPE_I,
    parameter logic [7:0] TYPE_D = loader_pkg::TYPE_D,
    parameter logic [7:0] TYPE_E = loader_pkg::TYPE_E
) (
    input  logic         clk_op,
    input  logic         rst_D4,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         busy,
    output logic         load_done,
    output logic         err
);
    import loader_pkg::*;

    state_t              state_reg, state_next;
    logic [7:0]          base_reg;
    logic [7:0]          idx_reg;
    logic [7:0]          rem_reg;
    logic [7:0]          hi_reg;
    logic                sect_data_reg;
    logic [MEM_AW-1:0]   addr_reg;
    logic [15:0]         data_reg;
    logic                inst_we_reg;
    logic                data_we_reg;
    logic                err_reg;

    logic                rx_ready_int;
    logic                byte_accept;
    logic                take_start;
    logic                type_known;
    logic [MEM_AW-1:0]   wr_addr;

    assign rx_ready_int = takes_bytes(state_reg);
    assign byte_accept  = bus.rx_valid & rx_ready_int;
    assign take_start   = start & ((state_reg == ST_IDLE) | (state_reg == ST_ERR));
    assign type_known   = (bus.rx_data == TYPE_I) | (bus.rx_data == TYPE_D);
    assign wr_addr      = MEM_AW'(base_reg + idx_reg);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_value;

    // Every byte from the first type byte through the end code is summed.
    loader_csum u_csum (
        .clk_op (clk_op),
        .rst_D4 (rst_D4),
        .clr    (take_start),
        .add    (byte_accept & (state_reg != ST_CHK)),
        .din    (bus.rx_data),
        .value  (csum_value)
    );
`endif

    always_ff @(posedge clk_op or negedge rst_D4) begin
        if (!rst_D4) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_HDR_TYPE;
            end
            ST_HDR_TYPE: begin
                if (byte_accept) begin
                    if (type_known) begin
                        state_next = ST_HDR_BASE;
                    end else if (bus.rx_data == TYPE_E) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = ST_CHK;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_HDR_BASE: begin
                if (byte_accept) state_next = ST_HDR_CNT;
            end
            ST_HDR_CNT: begin
                if (byte_accept) state_next = ST_WORD_HI;
            end
            ST_WORD_HI: begin
                if (byte_accept) state_next = ST_WORD_LO;
            end
            ST_WORD_LO: begin
                // rem counts down from count; count 0 wraps through 255 and gives 256 words
                if (byte_accept) state_next = (rem_reg == 8'd1) ? ST_HDR_TYPE : ST_WORD_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_accept) state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                if (start) state_next = ST_HDR_TYPE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_op or negedge rst_D4) begin
        if (!rst_D4) begin
            base_reg      <= 8'd0;
            idx_reg       <= 8'd0;
            rem_reg       <= 8'd0;
            hi_reg        <= 8'd0;
            sect_data_reg <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= 16'd0;
            inst_we_reg   <= 1'b0;
            data_we_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (take_start) begin
                err_reg <= 1'b0;
            end
            if (byte_accept) begin
                case (state_reg)
                    ST_HDR_TYPE: sect_data_reg <= (bus.rx_data == TYPE_D);
                    ST_HDR_BASE: begin
                        base_reg <= bus.rx_data;
                        idx_reg  <= 8'd0;
                    end
                    ST_HDR_CNT:  rem_reg <= bus.rx_data;
                    ST_WORD_HI:  hi_reg  <= bus.rx_data;
                    ST_WORD_LO: begin
                        // Enables are levels: the new section's enable takes over
                        // from the old one in the same cycle, so their OR never dips.
                        data_reg    <= {hi_reg, bus.rx_data};
                        addr_reg    <= wr_addr;
                        inst_we_reg <= ~sect_data_reg;
                        data_we_reg <= sect_data_reg;
                        idx_reg     <= idx_reg + 8'd1;
                        rem_reg     <= rem_reg - 8'd1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (bus.rx_data != csum_value) err_reg <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            if (state_next == ST_ERR && state_reg != ST_ERR) begin
                err_reg <= 1'b1;
            end
            // The single falling edge of the enables, which starts the core.
            if (state_next == ST_DONE && state_reg != ST_DONE) begin
                inst_we_reg <= 1'b0;
                data_we_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_addr
            if (gi < MEM_AW) begin : g_bit
                assign bus.ext_addr[gi] = addr_reg[gi];
            end else begin : g_zero
                assign bus.ext_addr[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.rx_ready    = rx_ready_int;
    assign bus.ext_inst_we = inst_we_reg;
    assign bus.ext_data_we = data_we_reg;
    assign bus.ext_data    = data_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign load_done       = (state_reg == ST_DONE);
    assign err             = err_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of single-section frames plus hand-written corner sequences.
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  base;
        logic [7:0]  cnt;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        exp_isd;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
    } vec_t;

    logic clk_op = 1'b0;
    logic rst_D4 = 1'b0;
    logic start  = 1'b0;
    logic busy, load_done, err;

    prog_loader_if bus ();

    prog_loader #(.MEM_AW(8)) dut (
        .clk_op    (clk_op),
        .rst_D4    (rst_D4),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk_op = ~clk_op;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: a write is logged whenever the enabled (type, addr, data) changes.
    logic [15:0] mon_addr_q[$];
    logic [15:0] mon_data_q[$];
    logic        mon_isd_q[$];
    int          fall_cnt = 0, done_cnt = 0, drop_cnt = 0, both_cnt = 0;
    logic        or_prev = 1'b0, seen = 1'b0, have_last = 1'b0;
    logic        mon_or;
    logic [32:0] mon_key, last_key;
    logic [7:0]  last_chk_byte;

    always @(negedge clk_op) begin
        mon_or  = bus.ext_inst_we | bus.ext_data_we;
        mon_key = {bus.ext_data_we, bus.ext_addr, bus.ext_data};
        if (or_prev && !mon_or) fall_cnt++;
        if (bus.ext_inst_we && bus.ext_data_we) both_cnt++;
        if (mon_or && (!have_last || mon_key != last_key)) begin
            mon_addr_q.push_back(bus.ext_addr);
            mon_data_q.push_back(bus.ext_data);
            mon_isd_q.push_back(bus.ext_data_we);
            last_key  = mon_key;
            have_last = 1'b1;
        end
        if (!mon_or) have_last = 1'b0;
        if (seen && !mon_or && busy && !load_done) drop_cnt++;
        if (mon_or) seen = 1'b1;
        if (load_done || !rst_D4) seen = 1'b0;
        if (load_done) done_cnt++;
        or_prev = mon_or;
    end

    task automatic clear_mon();
        mon_addr_q.delete();
        mon_data_q.delete();
        mon_isd_q.delete();
        fall_cnt = 0;
        done_cnt = 0;
        drop_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk_op); #1;
        start = 1'b1;
        @(posedge clk_op); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int   guard;
        logic rdy;
        if (stall && $urandom_range(0, 1) == 1) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk_op);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        guard = 0;
        rdy   = 1'b0;
        while (!rdy && guard < 40) begin
            @(negedge clk_op);
            rdy = bus.rx_ready;
            @(posedge clk_op); #1;
            guard++;
        end
        bus.rx_valid = 1'b0;
        if (!rdy) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input bq_t f, input bit stall, input bit bad_chk);
        logic [7:0] sum;
        int         guard;
        clear_mon();
        pulse_start();
        sum = 8'd0;
        foreach (f[i]) begin
            send_byte(f[i], stall);
            sum = sum + f[i];
        end
        last_chk_byte = bad_chk ? ~sum : sum;
`ifdef LOADER_CHECKSUM_EN
        send_byte(last_chk_byte, stall);
`endif
        guard = 0;
        do begin
            @(posedge clk_op); #2;
            guard++;
        end while (!(done_cnt > 0 && !busy) && guard < 20);
        if (guard >= 20) chk("session_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_write(input string name, input int k, input logic isd,
                             input logic [15:0] a, input logic [15:0] d);
        if (mon_addr_q.size() > k) begin
            chk({name, "_type"}, 32'(mon_isd_q[k]), 32'(isd));
            chk({name, "_addr"}, 32'(mon_addr_q[k]), 32'(a));
            chk({name, "_data"}, 32'(mon_data_q[k]), 32'(d));
        end else begin
            chk({name, "_missing"}, 32'(mon_addr_q.size()), 32'(k + 1));
        end
    endtask

    vec_t vt[4];
    bq_t  fr;
    bq_t  frame2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'h49, 8'h10, 8'h02, 16'h1234, 16'h5678, 1'b0, 16'h0010, 16'h0011};
        vt[1] = '{8'h44, 8'hFF, 8'h02, 16'hAAAA, 16'h5555, 1'b1, 16'h00FF, 16'h0000};
        vt[2] = '{8'h49, 8'hFE, 8'h01, 16'hBEEF, 16'h0000, 1'b0, 16'h00FE, 16'h0000};
        vt[3] = '{8'h44, 8'h80, 8'h02, 16'h0001, 16'h8000, 1'b1, 16'h0080, 16'h0081};
        frame2 = '{8'h49, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h45};

        // Reset with a byte on offer: nothing moves until start.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h49;
        repeat (3) @(negedge clk_op);
        chk("rst_outputs", {busy, load_done, err, bus.rx_ready, bus.ext_inst_we, bus.ext_data_we},
            32'd0);
        chk("rst_addr_data", {bus.ext_addr, bus.ext_data}, 32'd0);
        rst_D4 = 1'b1;
        repeat (5) @(negedge clk_op);
        chk("idle_ignores_rx", {busy, bus.rx_ready, err, bus.ext_inst_we}, 32'd0);
        @(posedge clk_op); #1;
        bus.rx_valid = 1'b0;
        $display("reset/idle checks done");

        for (int k = 0; k < 4; k++) begin
            fr = '{vt[k].typ, vt[k].base, vt[k].cnt, vt[k].w0[15:8], vt[k].w0[7:0]};
            if (vt[k].cnt == 8'd2) begin
                fr.push_back(vt[k].w1[15:8]);
                fr.push_back(vt[k].w1[7:0]);
            end
            fr.push_back(8'h45);
            run_frame(fr, 1'b0, 1'b0);
            chk($sformatf("v%0d_nwrites", k), 32'(mon_addr_q.size()), 32'(vt[k].cnt));
            chk_write($sformatf("v%0d_w0", k), 0, vt[k].exp_isd, vt[k].exp_a0, vt[k].w0);
            if (vt[k].cnt == 8'd2)
                chk_write($sformatf("v%0d_w1", k), 1, vt[k].exp_isd, vt[k].exp_a1, vt[k].w1);
            chk($sformatf("v%0d_falls", k), 32'(fall_cnt), 32'd1);
            chk($sformatf("v%0d_done", k), 32'(done_cnt), 32'd1);
            chk($sformatf("v%0d_drops", k), 32'(drop_cnt), 32'd0);
            chk($sformatf("v%0d_err", k), 32'(err), 32'd0);
            $display("vector %0d: type %h base %h cnt %0d -> %0d writes", k,
                     vt[k].typ, vt[k].base, vt[k].cnt, mon_addr_q.size());
        end

        // Section change I -> D with address wrap.
        fr = '{8'h49, 8'h00, 8'h01, 8'h11, 8'h11,
               8'h44, 8'hFF, 8'h02, 8'h22, 8'h22, 8'h33, 8'h33, 8'h45};
        run_frame(fr, 1'b0, 1'b0);
        chk("swap_nwrites", 32'(mon_addr_q.size()), 32'd3);
        chk_write("swap_w0", 0, 1'b0, 16'h0000, 16'h1111);
        chk_write("swap_w1", 1, 1'b1, 16'h00FF, 16'h2222);
        chk_write("swap_w2", 2, 1'b1, 16'h0000, 16'h3333);
        chk("swap_both_high", 32'(both_cnt), 32'd0);
        chk("swap_drops", 32'(drop_cnt), 32'd0);
        chk("swap_falls", 32'(fall_cnt), 32'd1);
        $display("I->D swap session: %0d writes", mon_addr_q.size());

        // Unknown type byte after one written section.
        clear_mon();
        pulse_start();
        fr = '{8'h49, 8'h20, 8'h01, 8'hAB, 8'hCD, 8'h7A};
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        repeat (2) begin @(posedge clk_op); #2; end
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd1);
        chk("bad_we_held", {bus.ext_inst_we, bus.ext_addr, bus.ext_data}, {1'b1, 16'h0020, 16'hABCD});
        chk("bad_no_rx", 32'(bus.rx_ready), 32'd0);
        chk("bad_falls", 32'(fall_cnt), 32'd0);
        chk("bad_done", 32'(done_cnt), 32'd0);
        run_frame(frame2, 1'b0, 1'b0);
        chk("recover_err", 32'(err), 32'd0);
        chk("recover_done", 32'(done_cnt), 32'd1);
        chk_write("recover_w0", 0, 1'b0, 16'h0010, 16'h1234);
        chk_write("recover_w1", 1, 1'b0, 16'h0011, 16'h5678);
        chk("recover_falls", 32'(fall_cnt), 32'd1);
        $display("bad type session: err seen, recovery load_done=%0d", done_cnt);

        // count == 0 -> 256 words, with and without input stalls.
        for (int s = 0; s < 2; s++) begin
            int bad_w;
            fr = '{8'h49, 8'h40, 8'h00};
            for (int i = 0; i < 256; i++) begin
                fr.push_back(8'(i));
                fr.push_back(8'(i) ^ 8'h5A);
            end
            fr.push_back(8'h45);
            run_frame(fr, s[0], 1'b0);
            chk($sformatf("w256_s%0d_n", s), 32'(mon_addr_q.size()), 32'd256);
            bad_w = 0;
            for (int i = 0; i < 256 && i < mon_addr_q.size(); i++) begin
                chk($sformatf("w256_s%0d_addr%0d", s, i), 32'(mon_addr_q[i]),
                    32'((8'h40 + i) & 8'hFF));
                chk($sformatf("w256_s%0d_data%0d", s, i), 32'(mon_data_q[i]),
                    32'({8'(i), 8'(i) ^ 8'h5A}));
            end
            chk($sformatf("w256_s%0d_drops", s), 32'(drop_cnt), 32'd0);
            chk($sformatf("w256_s%0d_falls", s), 32'(fall_cnt), 32'd1);
            $display("count=0 session stall=%0d: %0d writes", s, mon_addr_q.size());
        end

`ifdef LOADER_CHECKSUM_EN
        run_frame(frame2, 1'b0, 1'b1);
        chk("csum_bad_err", 32'(err), 32'd1);
        chk("csum_bad_done", 32'(done_cnt), 32'd1);
        run_frame(frame2, 1'b0, 1'b0);
        chk("csum_good_err", 32'(err), 32'd0);
        chk("csum_good_done", 32'(done_cnt), 32'd1);
        $display("checksum sessions: wrong byte and correct byte");
`endif

        // End code with no prior write: pulse, but no enable edge.
        run_frame('{8'h45}, 1'b0, 1'b0);
        chk("empty_done", 32'(done_cnt), 32'd1);
        chk("empty_falls", 32'(fall_cnt), 32'd0);
        $display("empty session: load_done=%0d falls=%0d", done_cnt, fall_cnt);

        // Reset in the middle of a word.
        clear_mon();
        pulse_start();
        fr = '{8'h49, 8'h10, 8'h02, 8'h12, 8'h34, 8'h56};
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        @(negedge clk_op);
        chk("midrst_pre_we", 32'(bus.ext_inst_we), 32'd1);
        rst_D4 = 1'b0;
        #1;
        chk("midrst_state", {busy, bus.rx_ready, bus.ext_inst_we, bus.ext_data_we}, 32'd0);
        chk("midrst_addr", 32'(bus.ext_addr), 32'd0);
        #3;
        @(negedge clk_op);
        rst_D4 = 1'b1;
        $display("mid-word reset applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
